// File: rtl/byte_receiver_if.sv
// byte_receiver_if: serial-in strobe/data and valid/ready word handshake for byte_receiver.
interface byte_receiver_if #(parameter int DATA_WIDTH = 8);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    logic                  enable;
    logic                  in;
    logic                  clear_overrun;
    logic                  data_ready;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic [CW-1:0]         bit_count;
    logic                  overrun;
    modport master(
        output enable, in, clear_overrun, data_ready,
        input  data_out, data_valid, bit_count, overrun
    );
    modport slave(
        input  enable, in, clear_overrun, data_ready,
        output data_out, data_valid, bit_count, overrun
    );
endinterface

// File: rtl/byte_receiver.sv
// byte_receiver: serial-to-parallel deserializer with valid/ready holding register; BYTE_RECEIVER_MSB_FIRST_EN selects MSB-first word order.
module byte_receiver #(parameter int DATA_WIDTH = 8) (
    input logic            clk,
    input logic            reset,
    byte_receiver_if.slave bus
);
    localparam int CW = DATA_WIDTH > 1 ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t state, state_n;
    logic [DATA_WIDTH-1:0] shift, shift_n, word, data_out;
    logic [CW-1:0] bit_count;
    logic data_valid, overrun, last, load, abort;
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    always_comb begin
        last = bus.enable && bit_count == LAST;
        load = last && (!data_valid || bus.data_ready);
        abort = state == SHIFT && !bus.enable;
        state_n = (bus.enable && !last) ? SHIFT : IDLE;
        shift_n = shift;
        shift_n[bit_count] = bus.in;
        word = shift_n;
`ifdef BYTE_RECEIVER_MSB_FIRST_EN
        for (int i = 0; i < DATA_WIDTH; i++) word[i] = shift_n[DATA_WIDTH-1-i];
`endif
    end
    // Shift register stays zero whenever no word is in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift      <= '0;
            bit_count  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (bus.enable) begin
                shift     <= last ? '0 : shift_n;
                bit_count <= last ? '0 : bit_count + 1'b1;
            end else if (abort) begin
                shift     <= '0;
                bit_count <= '0;
            end
            if (load) data_out <= word;
            data_valid <= load || (data_valid && !bus.data_ready);
            overrun    <= (last && !load) || (overrun && !bus.clear_overrun);
        end
    end
    assign bus.data_out   = data_out;
    assign bus.data_valid = data_valid;
    assign bus.bit_count  = bit_count;
    assign bus.overrun    = overrun;
endmodule
